mem_resp_demux2: RTL and testbench

- Return-path partner of the 2:1 request mux in front of the shared Y86 memory port.
- The request side muxes fetch (sel=0) and data (sel=1) requests onto one memory port. This block records each issued select bit in order, then steers each in-order memory response back to the port that issued it.
- Each destination has a one-entry registered output with valid/ready.
- Sits between the unified memory and the fetch/memory pipeline stages.

---
 rtl/y86_mem_pkg.sv | 11 +
 rtl/sel_fifo.sv | 57 +++++
 rtl/mem_resp_demux2.sv | 127 ++++++++++++
 tb/tb_mem_resp_demux2.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/y86_mem_pkg.sv
// Shared constants for the Y86 unified memory port.
// Select encodings are common to the request mux and response demux.
package y86_mem_pkg;

  localparam logic SEL_FETCH = 1'b0;
  localparam logic SEL_DATA  = 1'b1;

  localparam int MEM_W           = 32;
  localparam int MEM_OUTSTANDING = 4;

endpackage

// File: rtl/sel_fifo.sv
// Small circular FIFO with explicit count.
// Push is ignored when full and pop when empty; there is no full bypass.
module sel_fifo
  import y86_mem_pkg::*;
#(
  parameter int W     = 1,
  parameter int DEPTH = MEM_OUTSTANDING,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_cnt == CW'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign count  = r_cnt;
  assign dout   = r_mem[r_rd];
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // Pointers wrap for free since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/mem_resp_demux2.sv
// Steers in-order memory responses back to the fetch or data port.
// Optional protocol checker: define MEM_RESP_DEMUX_CHECK_EN.
module mem_resp_demux2
  import y86_mem_pkg::*;
#(
  parameter int N     = MEM_W,
  parameter int DEPTH = MEM_OUTSTANDING,
  localparam int PW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_fire,
  input  logic          req_sel,
  output logic          req_ok,
  input  logic          resp_valid,
  input  logic [N-1:0]  resp_data,
  output logic          resp_ready,
  output logic          out0_valid,
  output logic [N-1:0]  out0_data,
  input  logic          out0_ready,
  output logic          out1_valid,
  output logic [N-1:0]  out1_data,
  input  logic          out1_ready,
  output logic [PW-1:0] pending,
  output logic          err
);

  logic         w_head;
  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_acc;
  logic         w_busy;
  logic         w_ld0;
  logic         w_ld1;
  logic         r_v0;
  logic         r_v1;
  logic [N-1:0] r_d0;
  logic [N-1:0] r_d1;

  assign w_push = req_fire & ~w_full;

  sel_fifo #(
    .W     (1),
    .DEPTH (DEPTH)
  ) u_sel_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (req_sel),
    .pop   (w_acc),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (pending)
  );

  // Head-of-line blocking: a stalled head port stalls everything behind it
  always_comb begin
    w_busy = 1'b0;
    unique case (1'b1)
      (w_head == SEL_DATA):  w_busy = r_v1 & ~out1_ready;
      default:               w_busy = r_v0 & ~out0_ready;
    endcase
  end

  assign req_ok     = ~w_full;
  assign resp_ready = ~w_empty & ~w_busy;
  assign w_acc      = resp_valid & resp_ready;
  assign w_ld0      = w_acc & (w_head == SEL_FETCH);
  assign w_ld1      = w_acc & (w_head == SEL_DATA);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_d0 <= '0;
      r_d1 <= '0;
    end else begin
      if (w_ld0) begin
        r_v0 <= 1'b1;
        r_d0 <= resp_data;
      end else if (out0_ready) begin
        r_v0 <= 1'b0;
      end
      if (w_ld1) begin
        r_v1 <= 1'b1;
        r_d1 <= resp_data;
      end else if (out1_ready) begin
        r_v1 <= 1'b0;
      end
    end
  end

  assign out0_valid = r_v0;
  assign out0_data  = r_d0;
  assign out1_valid = r_v1;
  assign out1_data  = r_d1;

`ifdef MEM_RESP_DEMUX_CHECK_EN
  logic w_viol;
  logic r_err;

  assign w_viol = (resp_valid & w_empty) | (req_fire & w_full);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_viol) begin
      r_err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && w_viol) begin
      $error("mem_resp_demux2: protocol violation");
    end
  end
`endif

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_resp_demux2.sv
// Scoreboard bench for mem_resp_demux2.
// Expected per-port data is queued on accept and compared as outputs appear.
`timescale 1ns/1ps
module tb_mem_resp_demux2;
  import y86_mem_pkg::*;

  localparam int N  = 32;
  localparam int D  = 4;
  localparam int PW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_fire;
  logic          req_sel;
  logic          req_ok;
  logic          resp_valid;
  logic [N-1:0]  resp_data;
  logic          resp_ready;
  logic          out0_valid;
  logic [N-1:0]  out0_data;
  logic          out0_ready;
  logic          out1_valid;
  logic [N-1:0]  out1_data;
  logic          out1_ready;
  logic [PW-1:0] pending;
  logic          err;

  int n_chk = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  bit           sel_q[$];
  logic [N-1:0] e0[$];
  logic [N-1:0] e1[$];
  bit           m_err = 1'b0;

  mem_resp_demux2 #(.N(N), .DEPTH(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_fire   (req_fire),
    .req_sel    (req_sel),
    .req_ok     (req_ok),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .out0_valid (out0_valid),
    .out0_data  (out0_data),
    .out0_ready (out0_ready),
    .out1_valid (out1_valid),
    .out1_data  (out1_data),
    .out1_ready (out1_ready),
    .pending    (pending),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model checks at negedge, then advances to the state after the next posedge
  always @(negedge clk) begin
    if (mon_en) begin
      int  cnt;
      bit  head;
      bit  rr;
      cnt  = sel_q.size();
      head = (cnt != 0) ? sel_q[0] : 1'b0;
      if (head) rr = (cnt != 0) && (e1.size() == 0 || out1_ready);
      else      rr = (cnt != 0) && (e0.size() == 0 || out0_ready);

      chk("pending", pending, cnt);
      chk("req_ok", req_ok, cnt != D);
      chk("resp_ready", resp_ready, rr);
      chk("out0_valid", out0_valid, e0.size() != 0);
      chk("out1_valid", out1_valid, e1.size() != 0);
      if (e0.size() != 0) chk("out0_data", out0_data, e0[0]);
      if (e1.size() != 0) chk("out1_data", out1_data, e1[0]);
      chk("err", err, m_err);

      if (reset) begin
        sel_q.delete();
        e0.delete();
        e1.delete();
        m_err = 1'b0;
      end else begin
        if (out0_ready && e0.size() != 0) void'(e0.pop_front());
        if (out1_ready && e1.size() != 0) void'(e1.pop_front());
        if (resp_valid && rr) begin
          void'(sel_q.pop_front());
          if (head) e1.push_back(resp_data);
          else      e0.push_back(resp_data);
        end
        if (req_fire && cnt != D) sel_q.push_back(req_sel);
`ifdef MEM_RESP_DEMUX_CHECK_EN
        if ((resp_valid && cnt == 0) || (req_fire && cnt == D)) m_err = 1'b1;
`endif
      end
    end
  end

  task automatic cyc(input bit f, input bit s, input bit v,
                     input logic [N-1:0] d);
    req_fire   = f;
    req_sel    = s;
    resp_valid = v;
    resp_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    reset      = 1'b1;
    req_fire   = 1'b0;
    req_sel    = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_out0_data", out0_data, 0);
    chk("rst_out1_data", out1_data, 0);
    @(posedge clk);
    #1;

    // basic routing 0,1,0
    cyc(1, SEL_FETCH, 0, '0);
    cyc(1, SEL_DATA,  0, '0);
    cyc(1, SEL_FETCH, 0, '0);
    cyc(0, 0, 1, 32'hA);
    cyc(0, 0, 1, 32'hB);
    cyc(0, 0, 1, 32'hC);
    idle(3);

    // fill, then refused push alongside a pop
    for (int i = 0; i < D; i++) cyc(1, SEL_FETCH, 0, '0);
    @(negedge clk);
    chk("full_req_ok", req_ok, 0);
    chk("full_pending", pending, D);
    @(posedge clk);
    #1;
    cyc(1, SEL_DATA, 1, 32'h55);
    for (int i = 0; i < D - 1; i++) cyc(0, 0, 1, 32'h60 + i);
    idle(2);

    // head-of-line stall
    out1_ready = 1'b0;
    cyc(1, SEL_DATA,  0, '0);
    cyc(1, SEL_FETCH, 0, '0);
    cyc(0, 0, 1, 32'h11);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h22);
    out1_ready = 1'b1;
    cyc(0, 0, 1, 32'h22);
    idle(3);

    // back-to-back fetch stream with pointer wrap
    cyc(1, SEL_FETCH, 0, '0);
    for (int i = 0; i < 7; i++) cyc(1, SEL_FETCH, 1, N'(i));
    cyc(0, 0, 1, 32'd7);
    idle(3);

    // reset mid-flight
    out1_ready = 1'b0;
    cyc(1, SEL_DATA,  0, '0);
    cyc(1, SEL_FETCH, 0, '0);
    cyc(1, SEL_FETCH, 0, '0);
    cyc(0, 0, 1, 32'h77);
    @(negedge clk);
    chk("mid_pending", pending, 2);
    chk("mid_out1_valid", out1_valid, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(0, 0, 0, '0);
    reset = 1'b0;
    out1_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_pending", pending, 0);
    chk("post_rst_valid", {out0_valid, out1_valid}, 0);
    chk("post_rst_ready", resp_ready, 0);
    @(posedge clk);
    #1;

    // stray response with nothing outstanding
    cyc(0, 0, 1, 32'hDEAD);
    idle(3);
    reset = 1'b1;
    cyc(0, 0, 0, '0);
    reset = 1'b0;
    idle(2);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
